// File: rtl/codec_init_seq.sv
// rtl/codec_init_seq.sv - WM8731 power-up register write sequencer feeding the i2c master
// Walks an 11-entry {reg, val} table with NACK retry and a per-write timeout.
module codec_init_seq #(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         GAP_CYCLES     = 5000,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         MAX_RETRY      = 3,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_end,
  input  logic        i2c_nack,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  step
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [3:0] LAST_STEP = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_WAIT, S_RETRY, S_GAP, S_DONE, S_ERROR
  } state_t;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h1E00;
      4'd1:    table_entry = 16'h0017;
      4'd2:    table_entry = 16'h0217;
      4'd3:    table_entry = 16'h0479;
      4'd4:    table_entry = 16'h0679;
      4'd5:    table_entry = 16'h0812;
      4'd6:    table_entry = 16'h0A00;
      4'd7:    table_entry = 16'h0C00;
      4'd8:    table_entry = 16'h0E42;
      4'd9:    table_entry = 16'h1000;
      4'd10:   table_entry = 16'h1201;
      default: table_entry = 16'h0000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      end_sync_q, nack_sync_q;
  logic            end_prev_q, start_prev_q, first_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            fail_q, fail_d;
  logic [23:0]     data_q, data_d;
  logic            go_q, go_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [3:0]      step_q, step_d;

  logic end_rise, end_fall, start_edge, tmo_hit, restart;

  assign end_rise   = end_sync_q[1] & ~end_prev_q;
  assign end_fall   = ~end_sync_q[1] & end_prev_q;
  assign start_edge = start & ~start_prev_q;
  assign tmo_hit    = (tmo_q == '0);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    data_d  = data_q;
    go_d    = go_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    step_d  = step_q;
    restart = 1'b0;

    case (state_q)
      S_IDLE: restart = start_edge | (AUTO_START & first_q);
      S_LOAD: begin
        data_d  = {DEV_ADDR, table_entry(step_q)};
        tmo_d   = TW'(TIMEOUT_CYCLES - 1);
        go_d    = 1'b1;
        state_d = S_ARM;
      end
      S_ARM: begin
        if (tmo_hit) begin
          go_d    = 1'b0;
          state_d = S_RETRY;
        end else begin
          tmo_d = tmo_q - 1'b1;
          if (end_fall) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmo_hit) begin
          go_d    = 1'b0;
          state_d = S_RETRY;
        end else begin
          tmo_d = tmo_q - 1'b1;
          if (end_rise) begin
            go_d = 1'b0;
            if (nack_sync_q[1]) begin
              state_d = S_RETRY;
            end else begin
              fail_d  = 1'b0;
              gap_d   = GW'(GAP_CYCLES - 1);
              state_d = S_GAP;
            end
          end
        end
      end
      S_RETRY: begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          fail_d  = 1'b1;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          // a failed write re-runs the same entry; a good one advances or finishes
          if (fail_q) begin
            state_d = S_LOAD;
          end else if (step_q == LAST_STEP) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 4'd1;
            retry_d = '0;
            state_d = S_LOAD;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE, S_ERROR: restart = start_edge;
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d = S_LOAD;
      busy_d  = 1'b1;
      step_d  = '0;
      retry_d = '0;
      fail_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      end_sync_q   <= '0;
      nack_sync_q  <= '0;
      end_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      first_q      <= 1'b1;
      tmo_q        <= '0;
      gap_q        <= '0;
      retry_q      <= '0;
      fail_q       <= 1'b0;
      data_q       <= '0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      step_q       <= '0;
    end else begin
      state_q      <= state_d;
      end_sync_q   <= {end_sync_q[0], i2c_end};
      nack_sync_q  <= {nack_sync_q[0], i2c_nack};
      end_prev_q   <= end_sync_q[1];
      start_prev_q <= start;
      first_q      <= 1'b0;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      retry_q      <= retry_d;
      fail_q       <= fail_d;
      data_q       <= data_d;
      go_q         <= go_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      step_q       <= step_d;
    end
  end

  assign i2c_data = data_q;
  assign i2c_go   = go_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign step     = step_q;

endmodule
